// File: rtl/regfile_swap_sequencer_pkg.sv
// regfile_seq_pkg: opcodes, sequencer states and default sizes shared by the swap sequencer files.
package regfile_seq_pkg;
  localparam int N_REGS_DEF = 8;
  localparam int DATA_W_DEF = 4;
  typedef enum logic [1:0] {
    OP_INIT    = 2'b00,
    OP_SWAP    = 2'b01,
    OP_REVERSE = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SWAP,
    S_REV,
    S_DONE
  } state_e;
endpackage

// File: rtl/regfile_swap_sequencer_swap_pair_gen.sv
// swap_pair_gen: maps a reverse step index to the mirrored (x, y) pair and flags the final pair.
module swap_pair_gen
  import regfile_seq_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              last_pair
);
  assign x = idx;
  assign y = ADDR_W'(N_REGS - 1) - idx;
  assign last_pair = idx == ADDR_W'(N_REGS / 2 - 1);
endmodule

// File: rtl/regfile_swap_sequencer.sv
// regfile_swap_sequencer: turns INIT/SWAP/REVERSE host commands into registered register-file control pulses.
// Optional SEQ_CHECK_EN adds a shadow model of the register file and a chk_err pulse on mismatch.
module regfile_swap_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_x,
  input  logic [ADDR_W-1:0] cmd_y,
  output logic              rf_init,
  output logic              rf_swap,
  output logic [ADDR_W-1:0] rf_x,
  output logic [ADDR_W-1:0] rf_y,
  output logic              busy,
  output logic              done,
`ifdef SEQ_CHECK_EN
  input  logic [DATA_W-1:0] rf_r [N_REGS],
  output logic              chk_err,
`endif
  output logic              cmd_err
);
  state_e state, nstate;
  logic [ADDR_W-1:0] idx, nidx, pair_x, pair_y;
  logic pair_last, last_q;

  swap_pair_gen #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) u_pair (
    .idx(nidx),
    .x(pair_x),
    .y(pair_y),
    .last_pair(pair_last)
  );

  assign cmd_ready = rst_n && state == S_IDLE;
  assign busy = state != S_IDLE;

  always_comb begin
    nstate = state;
    nidx = state == S_REV ? idx + 1'b1 : '0;
    case (state)
      S_IDLE: if (cmd_valid) nstate = cmd_op == OP_INIT ? S_INIT :
                                      cmd_op == OP_SWAP ? S_SWAP :
                                      cmd_op == OP_REVERSE ? S_REV : S_DONE;
      S_INIT, S_SWAP: nstate = S_DONE;
      S_REV: nstate = last_q ? S_DONE : S_REV;
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      last_q <= 1'b0;
      rf_init <= 1'b0;
      rf_swap <= 1'b0;
      rf_x <= '0;
      rf_y <= '0;
      done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      last_q <= pair_last;
      rf_init <= nstate == S_INIT;
      rf_swap <= (nstate == S_SWAP && cmd_x != cmd_y) || nstate == S_REV;
      rf_x <= nstate == S_SWAP ? cmd_x : nstate == S_REV ? pair_x : '0;
      rf_y <= nstate == S_SWAP ? cmd_y : nstate == S_REV ? pair_y : '0;
      done <= nstate == S_DONE;
      cmd_err <= nstate == S_DONE && state == S_IDLE;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [DATA_W-1:0] shadow [N_REGS];
  logic shadow_valid, mism;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_valid <= 1'b0;
      for (int i = 0; i < N_REGS; i++) shadow[i] <= '0;
    end else if (rf_init) begin
      shadow_valid <= 1'b1;
      for (int i = 0; i < N_REGS; i++) shadow[i] <= DATA_W'(i);
    end else if (rf_swap) begin
      shadow[rf_x] <= shadow[rf_y];
      shadow[rf_y] <= shadow[rf_x];
    end
  end

  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < N_REGS; i++) mism = mism | (rf_r[i] != shadow[i]);
  end

  assign chk_err = state == S_DONE && shadow_valid && mism;
`endif
endmodule
